// File: rtl/trivium_out_fifo.sv
// ---------------------------------------------------------------------------
// trivium_out_fifo
//
// Ciphertext-side output buffer of the Trivium encryptor. Each byte presented
// with wt_sgn is stored in a DEPTH x 8 on-chip memory. The bytes are drained
// to a downstream consumer through a one-entry output register using a
// valid/ready handshake. Buffer room is reported to the encryptor on the
// registered 2-bit fifo_cnd code. The encryptor starts a new BLOCK_LEN-byte
// block only when fifo_cnd == 2'b00.
//
// Parameters
//   DEPTH      storage entries in bytes (power of two, >= BLOCK_LEN)
//   BLOCK_LEN  bytes per encryptor block (room threshold, m_last period)
//
// Ports
//   clk         in   1   clock
//   rst         in   1   asynchronous active-low reset
//   stream      in   8   ciphertext byte from the encryptor
//   wt_sgn      in   1   write strobe; stream captured on every edge it is 1
//   enc_status  in   8   encryptor one-hot status; bit 6 (total reset) flushes
//   fifo_cnd    out  2   11 overflow, 00 block room, 10 full, 01 partial room
//   m_data      out  8   output byte
//   m_valid     out  1   m_data is valid
//   m_ready     in   1   consumer accepts the byte
//   level       out  AW+1 occupancy: memory plus output register
//   m_last      out  1   last byte of each BLOCK_LEN-byte block
//                        (present only when TRIV_FIFO_LAST_EN is defined)
//
// Configuration macro: TRIV_FIFO_LAST_EN adds the m_last port and the block
// counter that drives it. Without the macro both are absent.
// ---------------------------------------------------------------------------
module trivium_out_fifo #(
  parameter int DEPTH     = 512,
  parameter int BLOCK_LEN = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               stream,
  input  logic                     wt_sgn,
  input  logic [7:0]               enc_status,
  output logic [1:0]               fifo_cnd,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level
`ifdef TRIV_FIFO_LAST_EN
  ,
  output logic                     m_last
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] BLOCK_L = LW'(BLOCK_LEN);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_OVF   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] CND_ROOM    = 2'b00;
  localparam logic [1:0] CND_PARTIAL = 2'b01;
  localparam logic [1:0] CND_FULL    = 2'b10;
  localparam logic [1:0] CND_OVF     = 2'b11;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];

  state_t        state_q,    state_d;
  logic [AW-1:0] wp_q,       wp_d;
  logic [AW-1:0] rp_q,       rp_d;
  logic [LW-1:0] level_q,    level_d;
  logic          m_valid_q,  m_valid_d;
  logic [7:0]    m_data_q,   m_data_d;
  logic [1:0]    fifo_cnd_q, fifo_cnd_d;

`ifdef TRIV_FIFO_LAST_EN
  localparam int BW = $clog2(BLOCK_LEN);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLOCK_LEN - 1);
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
`endif

  logic wr_en;
  logic hs;
  logic flush;
  logic full;
  logic mem_empty;

  // Only the total-reset bit of the status word is of interest here.
  logic unused_status;
  assign unused_status = ^{enc_status[7], enc_status[5:0]};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch; blocking assignments are correct
  // in combinational logic.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    level_d    = level_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    fifo_cnd_d = fifo_cnd_q;
    wr_en      = 1'b0;
`ifdef TRIV_FIFO_LAST_EN
    blk_cnt_d  = blk_cnt_q;
`endif

    hs        = m_valid_q && m_ready;
    full      = (level_q == DEPTH_L);
    // level counts the output register too, so memory is empty when level
    // equals the output register's own contribution.
    mem_empty = (level_q == LW'(m_valid_q));
    // The clear is applied both on the edge that sees the total-reset bit and
    // during the FLUSH cycle itself, so nothing written in between survives.
    flush     = enc_status[6] || (state_q == ST_FLUSH);

    // FSM: total reset wins over everything, including a write this cycle.
    if (enc_status[6]) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (wt_sgn && full) state_d = ST_OVF;
        ST_OVF:   state_d = ST_OVF;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end

    if (flush) begin
      wp_d      = '0;
      rp_d      = '0;
      level_d   = '0;
      m_valid_d = 1'b0;
`ifdef TRIV_FIFO_LAST_EN
      blk_cnt_d = '0;
`endif
    end else begin
      // Writes are accepted only in RUN; in OVF they are silently ignored.
      wr_en = wt_sgn && !full && (state_q == ST_RUN);
      if (wr_en) wp_d = wp_q + AW'(1);

      // The output register refills when empty or when its byte is taken.
      // Memory emptiness is judged before this cycle's write, which gives the
      // one-edge write-to-output latency and avoids a same-address bypass.
      if (hs || !m_valid_q) begin
        if (!mem_empty) begin
          m_data_d  = mem[rp_q];
          m_valid_d = 1'b1;
          rp_d      = rp_q + AW'(1);
        end else begin
          m_valid_d = 1'b0;
        end
      end

      level_d = level_q + LW'(wr_en) - LW'(hs);

`ifdef TRIV_FIFO_LAST_EN
      if (hs) blk_cnt_d = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + BW'(1);
`endif
    end

    // Flow-control code is derived from next-cycle values so that it is in
    // step with level once registered.
    if (state_d == ST_OVF) begin
      fifo_cnd_d = CND_OVF;
    end else if ((DEPTH_L - level_d) >= BLOCK_L) begin
      fifo_cnd_d = CND_ROOM;
    end else if (level_d == DEPTH_L) begin
      fifo_cnd_d = CND_FULL;
    end else begin
      fifo_cnd_d = CND_PARTIAL;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      fifo_cnd_q <= CND_ROOM;
`ifdef TRIV_FIFO_LAST_EN
      blk_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      level_q    <= level_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      fifo_cnd_q <= fifo_cnd_d;
`ifdef TRIV_FIFO_LAST_EN
      blk_cnt_q  <= blk_cnt_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; pointers and level define which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= stream;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign fifo_cnd = fifo_cnd_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign level    = level_q;

`ifdef TRIV_FIFO_LAST_EN
  // The counter holds the in-block index of the byte currently presented.
  assign m_last = m_valid_q && (blk_cnt_q == BLK_LAST);
`endif

endmodule
